// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, drives the instruction ROM word
// address and captures the returned word into the IF/ID register. Handles
// decode stall, branch/jump redirect (one-bubble flush), syscall halt and
// misaligned-redirect fault.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall           decode back-pressure; holds PC and IF/ID contents
//   redirect_valid  branch/jump taken this cycle, target on redirect_pc
//   rom_addr        ROM word address, pc[11:2] (combinational from PC reg)
//   rom_data        ROM read data, valid in the same cycle
//   if_pc, if_pc_plus4, if_instr, if_valid   IF/ID register contents
//   halted          fetch stopped by HALT_INSTR (sticky until rst)
//   fault           misaligned redirect target seen (sticky until rst)
//   fetch_count     number of instructions delivered (wraps)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_plus4_q;
    logic [31:0] if_instr_q;
    logic        if_valid_q;
    logic        halted_q;
    logic        fault_q;
    logic [31:0] fetch_count_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] fetch_count_d;
    logic        redirect_aligned_d;
    logic        halt_hit_d;

    // Next-value helpers shared by the capture path.
    assign pc_plus4_d         = pc_q + 32'd4;
    assign fetch_count_d      = fetch_count_q + 32'd1;
    assign redirect_aligned_d = (redirect_pc[1:0] == 2'b00);
    assign halt_hit_d         = (rom_data == HALT_INSTR);

    // Upper PC bits are ignored, so fetch wraps modulo 4 KiB.
    assign rom_addr = pc_q[11:2];

    // Fetch FSM with registered IF/ID outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd0;
            if_instr_q    <= 32'd0;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (redirect_valid) begin
                        // Redirect beats stall and any same-edge halt capture:
                        // the word currently on rom_data is wrong-path.
                        if_valid_q <= 1'b0;
                        if (redirect_aligned_d) begin
                            pc_q       <= redirect_pc;
                            if_instr_q <= 32'd0;
                        end else begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_instr_q    <= rom_data;
                        if_pc_q       <= pc_q;
                        if_pc_plus4_q <= pc_plus4_d;
                        if_valid_q    <= 1'b1;
                        fetch_count_q <= fetch_count_d;
                        // The halting instruction is still delivered; PC parks on it.
                        if (halt_hit_d) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4_d;
                        end
                    end
                end
                S_HALT: begin
                    // A stall may hold the halting instruction; once it drains
                    // if_valid stays low and stall no longer matters.
                    if (!stall) begin
                        if_valid_q <= 1'b0;
                    end
                end
                S_FAULT: begin
                    if_valid_q <= 1'b0;
                    fault_q    <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely in FAULT.
                    state_q    <= S_FAULT;
                    fault_q    <= 1'b1;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a ROM model feeds two instances (default reset PC
// and reset PC 0xFFC). Expected deliveries are queued by the stimulus and
// popped by a monitor whenever fetch_count advances with if_valid high;
// control outputs are checked inline against hand-computed values.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] if_pc, if_pc_plus4, if_instr, fetch_count;
    logic        if_valid, halted, fault;

    logic        rst2 = 1'b1;
    logic        stall2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [31:0] redir_pc2 = 32'd0;
    logic [9:0]  rom_addr2;
    logic [31:0] rom_data2;
    logic [31:0] if_pc2, if_pc_plus42, if_instr2, fetch_count2;
    logic        if_valid2, halted2, fault2;

    logic [31:0] rom [1024];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_cnt = 32'd0;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    if_fetch_unit u_dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
        .if_valid(if_valid), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    if_fetch_unit #(.RESET_PC(32'h0000_0FFC)) u_dut2 (
        .clk(clk), .rst(rst2), .stall(stall2),
        .redirect_valid(redir2), .redirect_pc(redir_pc2),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .if_pc(if_pc2), .if_pc_plus4(if_pc_plus42), .if_instr(if_instr2),
        .if_valid(if_valid2), .halted(halted2), .fault(fault2),
        .fetch_count(fetch_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected delivery for the fetch at byte address pc, then clock.
    task automatic run1(input logic [31:0] pc, input logic [31:0] cnt);
        exp_t e;
        logic [9:0] wa;
        wa = pc[11:2];
        e.pc = pc;
        e.instr = rom[wa];
        e.cnt = cnt;
        exp_q.push_back(e);
        tick();
    endtask

    // Monitor: every new delivery is matched against the head of the queue.
    always @(posedge clk) begin
        #2;
        if (if_valid === 1'b1 && fetch_count !== last_cnt) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: pc %h instr %h, expected none", if_pc, if_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_if_pc", if_pc, e.pc);
                chk("mon_if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
                chk("mon_if_instr", if_instr, e.instr);
                chk("mon_fetch_count", fetch_count, e.cnt);
            end
        end
        last_cnt = fetch_count;
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 | 32'(i);
        rom[0] = 32'h1111_1111;
        rom[1] = 32'h2222_2222;
        rom[2] = 32'h3333_3333;
        rom[3] = 32'h4444_4444;

        // Reset state
        tick();
        tick();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;

        // Free run, then stall while if_pc=4
        run1(32'h0, 32'd1);
        chk("run_rom_addr1", 32'(rom_addr), 32'd1);
        run1(32'h4, 32'd2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_if_pc", if_pc, 32'h4);
            chk("stall_if_instr", if_instr, 32'h2222_2222);
            chk("stall_rom_addr", 32'(rom_addr), 32'd2);
            chk("stall_fetch_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        run1(32'h8, 32'd3);
        chk("release_if_pc", if_pc, 32'h8);
        run1(32'hC, 32'd4);
        chk("run_fetch_count", fetch_count, 32'd4);
        chk("run_rom_addr4", 32'(rom_addr), 32'd4);

        // Redirect overrides stall
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        chk("redir_rom_addr", 32'(rom_addr), 32'h10);
        chk("redir_if_valid", 32'(if_valid), 32'd0);
        chk("redir_if_instr", if_instr, 32'd0);
        chk("redir_fetch_count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        stall = 1'b0;
        run1(32'h40, 32'd5);
        chk("redir_tgt_if_valid", 32'(if_valid), 32'd1);
        chk("redir_tgt_if_pc", if_pc, 32'h40);
        chk("redir_tgt_rom_addr", 32'(rom_addr), 32'h11);

        // Syscall halt at word 5
        rom[5] = 32'h0000_000C;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) run1(32'(4 * k), 32'(k + 1));
        chk("pre_halt_halted", 32'(halted), 32'd0);
        run1(32'h14, 32'd6);
        chk("halt_if_instr", if_instr, 32'h0000_000C);
        chk("halt_if_valid", 32'(if_valid), 32'd1);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_rom_addr", 32'(rom_addr), 32'd5);
        tick();
        chk("halt_bubble_if_valid", 32'(if_valid), 32'd0);
        chk("halt_fetch_count", fetch_count, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("halt_ignore_redir_addr", 32'(rom_addr), 32'd5);
        chk("halt_ignore_redir_halted", 32'(halted), 32'd1);
        rst = 1'b1;
        tick();
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_fetch_count", fetch_count, 32'd0);
        chk("halt_rst_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        run1(32'h0, 32'd1);
        chk("restart_if_valid", 32'(if_valid), 32'd1);

        // Misaligned redirect fault (pc is 4 here)
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        tick();
        chk("fault_fault", 32'(fault), 32'd1);
        chk("fault_if_valid", 32'(if_valid), 32'd0);
        chk("fault_rom_addr", 32'(rom_addr), 32'd1);
        redirect_pc = 32'h40;
        tick();
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_ignore_redir", 32'(rom_addr), 32'd1);
        redirect_valid = 1'b0;
        tick();
        chk("fault_no_fetch", fetch_count, 32'd1);
        chk("fault_still_invalid", 32'(if_valid), 32'd0);
        rst = 1'b1;
        tick();
        chk("fault_rst_clear", 32'(fault), 32'd0);

        // Address wrap from RESET_PC=0xFFC (first instance kept in reset)
        rst2 = 1'b0;
        chk("wrap_rom_addr0", 32'(rom_addr2), 32'h3FF);
        tick();
        chk("wrap_if_pc0", if_pc2, 32'hFFC);
        chk("wrap_if_instr0", if_instr2, 32'hA000_03FF);
        chk("wrap_rom_addr1", 32'(rom_addr2), 32'h000);
        tick();
        chk("wrap_if_pc1", if_pc2, 32'h1000);
        chk("wrap_if_pc_plus4", if_pc_plus42, 32'h1004);
        chk("wrap_if_instr1", if_instr2, 32'h1111_1111);
        chk("wrap_fault", 32'(fault2), 32'd0);
        chk("wrap_fetch_count", fetch_count2, 32'd2);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
